pro: RTL and testbench

Single-byte I2C master write engine. On a `start_tx` pulse it issues an I2C START, sends the 7-bit slave address with the write bit, and sends one data byte. It samples the slave ACK after each byte, issues a STOP, and pulses `done`. It sits between a local controller and the board-level SCL/SDA pads; external open-drain conversion is the pad wrapper's job.

---
 rtl/pro_pkg.sv | 29 ++
 rtl/pro_if.sv | 22 ++
 rtl/pro_tick_gen.sv | 37 +++
 rtl/pro.sv | 134 +++++++++++++
 tb/tb_pro.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pro_pkg.sv
// Shared types and constants for the single-byte I2C master write engine.
package pro_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DIV_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } pro_state_t;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  // SCL is high in the second half of every clocked bit time
  function automatic logic scl_for_phase(input logic [1:0] ph);
    return ph[1];
  endfunction

endpackage

// File: rtl/pro_if.sv
// Controller-side request/status bundle plus the SCL/SDA pad-side outputs.
interface pro_if;
  import pro_pkg::*;

  logic              start_tx;
  logic [DATA_W-1:0] data_in;
  logic              ack_in;
  logic              scl;
  logic              sda;
  logic              done;
  logic              busy;

  modport master (
    output start_tx, data_in, ack_in,
    input  scl, sda, done, busy
  );

  modport slave (
    input  start_tx, data_in, ack_in,
    output scl, sda, done, busy
  );
endinterface

// File: rtl/pro_tick_gen.sv
// Quarter-SCL-period divider: one-clock tick at each phase boundary and a 2-bit phase count.
module pro_tick_gen
  import pro_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  output logic       o_tick_c,
  output logic       o_first_c,
  output logic [1:0] o_phase
);

  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_phase;

  assign o_tick_c  = !i_clr && (r_cnt == DIV_W'(CLK_DIV - 1));
  assign o_first_c = (r_cnt == '0);
  assign o_phase   = r_phase;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt   <= '0;
      r_phase <= PH_0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_phase <= PH_0;
    end else if (o_tick_c) begin
      r_cnt   <= '0;
      r_phase <= 2'(r_phase + 2'd1);
    end else begin
      r_cnt   <= DIV_W'(r_cnt + DIV_W'(1));
    end
  end

endmodule

// File: rtl/pro.sv
// Single-byte I2C master write: START, address+W, data byte, ACK samples, STOP, done pulse.
// Define PRO_ACK_CHECK_EN to abort to STOP when the address phase is NACKed.
module pro
  import pro_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic clk,
  input  logic rst_n,
  pro_if.slave bus
);

`ifdef PRO_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  localparam logic [DATA_W-1:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  pro_state_t        r_state, w_state_n;
  logic [BIT_W-1:0]  r_bit, w_bit_n;
  logic [DATA_W-1:0] r_shift, w_shift_n;
  logic              r_nack, w_nack;
  logic              r_scl, r_sda, r_done, r_busy;
  logic              w_scl_n, w_sda_n;
  logic              w_tick, w_first, w_end, w_clr;
  logic [1:0]        w_phase, w_phase_n;

  assign w_clr = (r_state == IDLE) || (r_state == DONE);

  pro_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .o_tick_c  (w_tick),
    .o_first_c (w_first),
    .o_phase   (w_phase)
  );

  assign w_end     = w_tick && (w_phase == PH_3);
  assign w_phase_n = w_tick ? 2'(w_phase + 2'd1) : w_phase;
  assign w_nack    = ((r_state == ADDR_ACK) && (w_phase == PH_3) && w_first) ? bus.ack_in : r_nack;

  // Outputs are derived from the next state/phase so they register in step with the FSM
  always_comb begin
    w_state_n = r_state;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_scl_n   = 1'b1;
    w_sda_n   = 1'b1;

    case (r_state)
      IDLE: if (bus.start_tx) begin
        w_state_n = START;
        w_shift_n = bus.data_in;
        w_bit_n   = '0;
      end
      START: if (w_end) w_state_n = ADDR;
      ADDR: if (w_end) begin
        if (r_bit == BIT_W'(7)) begin
          w_state_n = ADDR_ACK;
          w_bit_n   = '0;
        end else begin
          w_bit_n = BIT_W'(r_bit + BIT_W'(1));
        end
      end
      ADDR_ACK: if (w_end) w_state_n = (ACK_CHECK && w_nack) ? STOP : DATA;
      DATA: if (w_end) begin
        w_shift_n = {r_shift[DATA_W-2:0], 1'b0};
        if (r_bit == BIT_W'(7)) begin
          w_state_n = DATA_ACK;
          w_bit_n   = '0;
        end else begin
          w_bit_n = BIT_W'(r_bit + BIT_W'(1));
        end
      end
      DATA_ACK: if (w_end) w_state_n = STOP;
      STOP:     if (w_end) w_state_n = DONE;
      DONE:     w_state_n = IDLE;
      default:  w_state_n = IDLE;
    endcase

    case (w_state_n)
      START: w_sda_n = ~w_phase_n[1];
      ADDR: begin
        w_scl_n = scl_for_phase(w_phase_n);
        w_sda_n = ADDR_BYTE[BIT_W'(BIT_W'(7) - w_bit_n)];
      end
      DATA: begin
        w_scl_n = scl_for_phase(w_phase_n);
        w_sda_n = w_shift_n[DATA_W-1];
      end
      ADDR_ACK, DATA_ACK: w_scl_n = scl_for_phase(w_phase_n);
      STOP: begin
        w_scl_n = scl_for_phase(w_phase_n);
        w_sda_n = (w_phase_n == PH_3);
      end
      default: begin
        w_scl_n = 1'b1;
        w_sda_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_nack  <= 1'b0;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_nack  <= (r_state == IDLE) ? 1'b0 : w_nack;
      r_scl   <= w_scl_n;
      r_sda   <= w_sda_n;
      r_done  <= (w_state_n == DONE);
      r_busy  <= (w_state_n != IDLE);
    end
  end

  assign bus.scl  = r_scl;
  assign bus.sda  = r_sda;
  assign bus.done = r_done;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_pro.sv
// Directed bench for the I2C write engine: vector table plus reset and mid-transfer-reset sequences.
module tb_pro;

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic        chg;
    logic        second;
    int unsigned dut;
    logic [31:0] exp_bits;
    int unsigned exp_nbits;
    int unsigned exp_lat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pro_if if0();
  pro_if if1();

  pro #(.SLAVE_ADDR(7'h50), .CLK_DIV(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pro #(.SLAVE_ADDR(7'h50), .CLK_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus observer: bits on SCL rise, START/STOP conditions, done pulses and timing
  int unsigned nbits [2];
  int unsigned starts[2];
  int unsigned stops [2];
  int unsigned dones [2];
  int unsigned t_busy[2];
  int unsigned t_done[2];
  logic [31:0] bits  [2];
  logic        busy_at_done[2];
  logic        p_scl[2], p_sda[2], p_busy[2];
  logic        s_scl, s_sda, s_busy, s_done;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      s_scl  = (d == 0) ? if0.scl  : if1.scl;
      s_sda  = (d == 0) ? if0.sda  : if1.sda;
      s_busy = (d == 0) ? if0.busy : if1.busy;
      s_done = (d == 0) ? if0.done : if1.done;
      if (s_scl === 1'b1 && p_scl[d] === 1'b0) begin
        bits[d]  = {bits[d][30:0], s_sda};
        nbits[d] = nbits[d] + 1;
      end
      if (s_scl === 1'b1 && p_scl[d] === 1'b1 && p_sda[d] === 1'b1 && s_sda === 1'b0)
        starts[d] = starts[d] + 1;
      if (s_scl === 1'b1 && p_scl[d] === 1'b1 && p_sda[d] === 1'b0 && s_sda === 1'b1)
        stops[d] = stops[d] + 1;
      if (s_busy === 1'b1 && p_busy[d] !== 1'b1) t_busy[d] = cyc;
      if (s_done === 1'b1) begin
        dones[d]        = dones[d] + 1;
        t_done[d]       = cyc;
        busy_at_done[d] = s_busy;
      end
      p_scl[d]  = s_scl;
      p_sda[d]  = s_sda;
      p_busy[d] = s_busy;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_n();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned d, input logic st, input logic [7:0] dat, input logic ack);
    if (d == 0) begin
      if0.start_tx = st; if0.data_in = dat; if0.ack_in = ack;
    end else begin
      if1.start_tx = st; if1.data_in = dat; if1.ack_in = ack;
    end
  endtask

  function automatic logic [3:0] outs(input int unsigned d);
    return (d == 0) ? {if0.scl, if0.sda, if0.busy, if0.done}
                    : {if1.scl, if1.sda, if1.busy, if1.done};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned b_n, b_st, b_sp, b_dn, w, d;
    logic [31:0] mask;
    logic [7:0]  dat;
    d   = v.dut;
    dat = v.data;
    tick_n();
    b_n = nbits[d]; b_st = starts[d]; b_sp = stops[d]; b_dn = dones[d];
    drive(d, 1'b1, dat, v.ack);
    tick_n();
    if (v.chg) dat = 8'h3C;
    drive(d, 1'b0, dat, v.ack);
    w = 0;
    while (w < 2000 && dones[d] == b_dn) begin
      if (v.second && w == 40) drive(d, 1'b1, dat, v.ack);
      if (v.second && w == 41) drive(d, 1'b0, dat, v.ack);
      tick_n();
      w++;
    end
    if (dones[d] == b_dn) begin
      checks++;
      failures++;
      $display("FAIL v%0d_timeout: no done after %0d cycles", idx, w);
    end
    repeat (3) tick_n();
    mask = (32'd1 << v.exp_nbits) - 32'd1;
    chk($sformatf("v%0d_bits", idx),   bits[d] & mask, v.exp_bits & mask);
    chk($sformatf("v%0d_nbits", idx),  nbits[d] - b_n, v.exp_nbits);
    chk($sformatf("v%0d_start", idx),  starts[d] - b_st, 1);
    chk($sformatf("v%0d_stop", idx),   stops[d] - b_sp, 1);
    chk($sformatf("v%0d_done", idx),   dones[d] - b_dn, 1);
    chk($sformatf("v%0d_lat", idx),    t_done[d] - t_busy[d], v.exp_lat);
    chk($sformatf("v%0d_busydn", idx), 32'(busy_at_done[d]), 1);
    chk($sformatf("v%0d_idle", idx),   32'(outs(d)), 32'(4'b1100));
  endtask

  vec_t tbl[8];

  initial begin
    int unsigned b_dn;
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 0, 32'({8'hA0, 1'b1, 8'hA5, 2'b10}), 19, 320};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 32'({8'hA0, 1'b1, 8'h3C, 2'b10}), 19, 320};
    tbl[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 0, 32'({8'hA0, 1'b1, 8'hFF, 2'b10}), 19, 320};
    tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 32'({8'hA0, 1'b1, 8'h00, 2'b10}), 19, 320};
    tbl[4] = '{8'hA5, 1'b0, 1'b1, 1'b0, 0, 32'({8'hA0, 1'b1, 8'hA5, 2'b10}), 19, 320};
    tbl[5] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0, 32'({8'hA0, 1'b1, 8'hA5, 2'b10}), 19, 320};
`ifdef PRO_ACK_CHECK_EN
    tbl[6] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0, 32'({8'hA0, 2'b10}), 10, 176};
`else
    tbl[6] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0, 32'({8'hA0, 1'b1, 8'hA5, 2'b10}), 19, 320};
`endif
    tbl[7] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1, 32'({8'hA0, 1'b1, 8'hA5, 2'b10}), 19, 80};

    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);

    // Reset held for two clocks, then released
    tick_n();
    tick_n();
    chk("rst_during_d0", 32'(outs(0)), 32'(4'b1100));
    chk("rst_during_d1", 32'(outs(1)), 32'(4'b1100));
    rst_n = 1'b0;
    tick_n();
    tick_n();
    chk("rst_after_d0", 32'(outs(0)), 32'(4'b1100));
    chk("rst_after_d1", 32'(outs(1)), 32'(4'b1100));

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Reset asserted during DATA bit 3 on the CLK_DIV=4 engine
    tick_n();
    b_dn = dones[0];
    drive(0, 1'b1, 8'hA5, 1'b0);
    tick_n();
    drive(0, 1'b0, 8'hA5, 1'b0);
    repeat (213) tick_n();
    chk("mr_busy_pre", 32'(if0.busy), 1);
    #2 rst_n = 1'b1;
    #1 chk("mr_async", 32'(outs(0)), 32'(4'b1100));
    tick_n();
    tick_n();
    chk("mr_held", 32'(outs(0)), 32'(4'b1100));
    rst_n = 1'b0;
    repeat (400) tick_n();
    chk("mr_no_done", dones[0] - b_dn, 0);
    chk("mr_idle", 32'(outs(0)), 32'(4'b1100));
    run_vec(tbl[0], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
